// File: rtl/bexkat_pkg.sv
// bexkat_pkg: shared types, widths and grant choice for the DDRAM arbiter
package bexkat_pkg;

    typedef enum logic [1:0] {IDLE, CMD, RDATA} state_t;
    typedef enum logic {VID, CPU} owner_t;

    localparam int DDR_DATA_W = 64;
    localparam int DDR_BE_W   = 8;

    // Urgent video wins; otherwise alternate on contention, else the sole requester
    function automatic owner_t pick_grant(input logic vid, input logic cpu, input logic urgent,
                                          input owner_t last);
        return (urgent && vid) ? VID :
               (vid && cpu)    ? ((last == VID) ? CPU : VID) :
               vid             ? VID : CPU;
    endfunction

endpackage

// File: rtl/ddram_arbiter.sv
// ddram_arbiter: shares one DDRAM port between video burst reads and CPU single beats
module ddram_arbiter
    import bexkat_pkg::*;
#(
    parameter int VID_BURST = 8,
    parameter int ADDR_W    = 29
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  vid_req,
    input  logic                  vid_urgent,
    input  logic [ADDR_W-1:0]     vid_addr,
    output logic                  vid_ack,
    output logic [DDR_DATA_W-1:0] vid_data,
    output logic                  vid_valid,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_W-1:0]     cpu_addr,
    input  logic [DDR_BE_W-1:0]   cpu_be,
    input  logic [DDR_DATA_W-1:0] cpu_wdata,
    output logic [DDR_DATA_W-1:0] cpu_rdata,
    output logic                  cpu_ack,
    input  logic                  ddram_busy,
    output logic [7:0]            ddram_burstcnt,
    output logic [ADDR_W-1:0]     ddram_addr,
    output logic                  ddram_rd,
    output logic                  ddram_we,
    output logic [DDR_DATA_W-1:0] ddram_din,
    output logic [DDR_BE_W-1:0]   ddram_be,
    input  logic [DDR_DATA_W-1:0] ddram_dout,
    input  logic                  ddram_dout_ready
);

    localparam logic [7:0] LAST_BEAT = 8'(VID_BURST - 1);

    state_t     state;
    owner_t     owner;
    owner_t     last_grant;
    owner_t     pick;
    logic [7:0] count;
    logic       want_vid;
    logic       want_cpu;

    // A requester still sees its own ack this cycle and has not dropped req yet
    assign want_vid = vid_req && !vid_ack;
    assign want_cpu = cpu_req && !cpu_ack;
    assign pick     = pick_grant(want_vid, want_cpu, vid_urgent, last_grant);

    // Arbitration FSM: grant in IDLE, hold command against busy, collect read beats
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state          <= IDLE;
            owner          <= VID;
            last_grant     <= VID;
            count          <= '0;
            vid_ack        <= 1'b0;
            vid_data       <= '0;
            vid_valid      <= 1'b0;
            cpu_rdata      <= '0;
            cpu_ack        <= 1'b0;
            ddram_burstcnt <= '0;
            ddram_addr     <= '0;
            ddram_rd       <= 1'b0;
            ddram_we       <= 1'b0;
            ddram_din      <= '0;
            ddram_be       <= '0;
        end else begin
            vid_ack   <= 1'b0;
            vid_valid <= 1'b0;
            cpu_ack   <= 1'b0;
            case (state)
                IDLE: if (want_vid || want_cpu) begin
                    state          <= CMD;
                    owner          <= pick;
                    last_grant     <= pick;
                    ddram_addr     <= (pick == VID) ? vid_addr : cpu_addr;
                    ddram_burstcnt <= (pick == VID) ? 8'(VID_BURST) : 8'd1;
                    ddram_be       <= (pick == VID) ? '1 : cpu_be;
                    ddram_din      <= cpu_wdata;
                    ddram_rd       <= (pick == VID) || !cpu_we;
                    ddram_we       <= (pick == CPU) && cpu_we;
                end
                CMD: if (!ddram_busy) begin
                    ddram_rd <= 1'b0;
                    ddram_we <= 1'b0;
                    count    <= '0;
                    vid_ack  <= (owner == VID);
                    cpu_ack  <= ddram_we;
                    state    <= ddram_we ? IDLE : RDATA;
                end
                RDATA: if (ddram_dout_ready) begin
                    if (owner == VID) begin
                        vid_data  <= ddram_dout;
                        vid_valid <= 1'b1;
                        count     <= count + 8'd1;
                        if (count == LAST_BEAT) state <= IDLE;
                    end else begin
                        cpu_rdata <= ddram_dout;
                        cpu_ack   <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ddram_arbiter.sv
// tb_ddram_arbiter: directed vectors and hand-written sequences for ddram_arbiter
module tb_ddram_arbiter;

    localparam int AW = 29;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [7:0]    be;
        logic [63:0]   wdata;
        int            busy;
        int            lat;
        logic [63:0]   beat;
        logic [63:0]   exp_rdata;
    } cpu_vec_t;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          vid_req = 1'b0, vid_urgent = 1'b0;
    logic [AW-1:0] vid_addr = '0;
    logic          vid_ack, vid_valid;
    logic [63:0]   vid_data;
    logic          cpu_req = 1'b0, cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [7:0]    cpu_be = '0;
    logic [63:0]   cpu_wdata = '0;
    logic [63:0]   cpu_rdata;
    logic          cpu_ack;
    logic          ddram_busy = 1'b0;
    logic [7:0]    ddram_burstcnt;
    logic [AW-1:0] ddram_addr;
    logic          ddram_rd, ddram_we;
    logic [63:0]   ddram_din;
    logic [7:0]    ddram_be;
    logic [63:0]   ddram_dout = '0;
    logic          ddram_dout_ready = 1'b0;

    int          n_chk = 0, n_fail = 0;
    int          vv_cnt = 0, ack_cnt = 0, both_hi = 0;
    logic [63:0] vid_log [256];
    cpu_vec_t    vecs [5];

    ddram_arbiter #(.VID_BURST(8), .ADDR_W(AW)) dut (
        .clk(clk), .reset_n(reset_n),
        .vid_req(vid_req), .vid_urgent(vid_urgent), .vid_addr(vid_addr),
        .vid_ack(vid_ack), .vid_data(vid_data), .vid_valid(vid_valid),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_be(cpu_be),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .ddram_busy(ddram_busy), .ddram_burstcnt(ddram_burstcnt), .ddram_addr(ddram_addr),
        .ddram_rd(ddram_rd), .ddram_we(ddram_we), .ddram_din(ddram_din), .ddram_be(ddram_be),
        .ddram_dout(ddram_dout), .ddram_dout_ready(ddram_dout_ready)
    );

    always #5 clk = ~clk;

    // Log every video beat, count CPU acks and any cycle with rd and we both high
    always @(negedge clk) begin
        if (vid_valid) begin
            if (vv_cnt < 256) vid_log[vv_cnt] = vid_data;
            vv_cnt++;
        end
        if (cpu_ack) ack_cnt++;
        if (ddram_rd && ddram_we) both_hi++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_reset(input string name);
        chk({name, "_ctl"}, 64'({vid_ack, vid_valid, cpu_ack, ddram_rd, ddram_we, ddram_burstcnt, ddram_be}), 64'd0);
        chk({name, "_addr"}, 64'(ddram_addr), 64'd0);
        chk({name, "_vid_data"}, vid_data, 64'd0);
        chk({name, "_cpu_rdata"}, cpu_rdata, 64'd0);
        chk({name, "_din"}, ddram_din, 64'd0);
    endtask

    task automatic wait_cmd(input string name);
        int k = 0;
        while (!(ddram_rd || ddram_we) && k < 40) begin
            tick;
            k++;
        end
        chk(name, 64'(ddram_rd | ddram_we), 64'd1);
    endtask

    task automatic hold_busy(input int n, input logic rd, input logic [AW-1:0] a);
        for (int i = 0; i < n; i++) begin
            tick;
            chk("cmd_held", 64'({ddram_rd, ddram_we}), rd ? 64'd2 : 64'd1);
            chk("cmd_addr_stable", 64'(ddram_addr), 64'(a));
        end
        ddram_busy = 1'b0;
    endtask

    task automatic feed(input logic [63:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            ddram_dout = base + 64'(i);
            ddram_dout_ready = 1'b1;
            tick;
        end
        ddram_dout_ready = 1'b0;
        tick;
    endtask

    task automatic vid_cmd(input logic [AW-1:0] a, input int busy);
        wait_cmd("vid_cmd_seen");
        chk("vid_cmd_kind", 64'({ddram_rd, ddram_we}), 64'd2);
        chk("vid_cmd_addr", 64'(ddram_addr), 64'(a));
        chk("vid_burstcnt", 64'(ddram_burstcnt), 64'd8);
        hold_busy(busy, 1'b1, a);
        tick;
        chk("vid_accept", 64'({ddram_rd, vid_ack}), 64'd1);
        vid_req = 1'b0;
        tick;
        chk("vid_ack_pulse", 64'(vid_ack), 64'd0);
    endtask

    task automatic vid_beats(input int s, input logic [63:0] base);
        chk("vid_beat_count", 64'(vv_cnt - s), 64'd8);
        for (int i = 0; i < 8; i++) chk("vid_data_order", vid_log[s + i], base + 64'(i));
    endtask

    task automatic cpu_xfer(input cpu_vec_t v);
        int s = vv_cnt;
        int a0 = ack_cnt;
        ddram_busy = (v.busy > 0);
        cpu_we = v.we;
        cpu_addr = v.addr;
        cpu_be = v.be;
        cpu_wdata = v.wdata;
        cpu_req = 1'b1;
        wait_cmd("cpu_cmd_seen");
        chk("cpu_cmd_kind", 64'({ddram_rd, ddram_we}), v.we ? 64'd1 : 64'd2);
        chk("cpu_cmd_addr", 64'(ddram_addr), 64'(v.addr));
        chk("cpu_burstcnt", 64'(ddram_burstcnt), 64'd1);
        if (v.we) begin
            chk("cpu_be", 64'(ddram_be), 64'(v.be));
            chk("cpu_din", ddram_din, v.wdata);
        end
        hold_busy(v.busy, !v.we, v.addr);
        tick;
        chk("cpu_cmd_drop", 64'({ddram_rd, ddram_we}), 64'd0);
        if (!v.we) begin
            chk("cpu_ack_early", 64'(cpu_ack), 64'd0);
            repeat (v.lat) tick;
            ddram_dout = v.beat;
            ddram_dout_ready = 1'b1;
            tick;
            ddram_dout_ready = 1'b0;
            chk("cpu_rdata", cpu_rdata, v.exp_rdata);
        end
        chk("cpu_ack", 64'(cpu_ack), 64'd1);
        cpu_req = 1'b0;
        tick;
        chk("cpu_ack_single", 64'(ack_cnt - a0), 64'd1);
        chk("cpu_no_vid_valid", 64'(vv_cnt - s), 64'd0);
    endtask

    initial begin
        int       s;
        cpu_vec_t tv;
        vecs[0] = '{1'b1, 29'h100,      8'h0F, 64'h1111_2222_3333_4444, 0, 0,  64'h0,                   64'h0};
        vecs[1] = '{1'b0, 29'h1234,     8'h00, 64'h0,                   0, 10, 64'hDEADBEEF_01234567,   64'hDEADBEEF_01234567};
        vecs[2] = '{1'b1, 29'h1FFFFFFF, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 2, 0,  64'h0,                   64'h0};
        vecs[3] = '{1'b0, 29'h0,        8'h00, 64'h0,                   1, 1,  64'hA5A5_5A5A_0F0F_F0F0, 64'hA5A5_5A5A_0F0F_F0F0};
        vecs[4] = '{1'b1, 29'h0,        8'h80, 64'h8000_0000_0000_0001, 0, 0,  64'h0,                   64'h0};

        // Reset state, then a stray beat in IDLE must be ignored
        repeat (3) tick;
        chk_reset("reset");
        reset_n = 1'b1;
        tick;
        feed(64'hBEEF, 1);
        chk("idle_stray_beat", 64'(vv_cnt + ack_cnt), 64'd0);

        // CPU vectors: writes with byte enables, reads with latency, busy stalls
        for (int i = 0; i < 5; i++) cpu_xfer(vecs[i]);

        // Video burst with busy held 3 cycles, then a stray beat after the burst
        ddram_busy = 1'b1;
        vid_addr = 29'h2000;
        vid_req = 1'b1;
        vid_cmd(29'h2000, 3);
        s = vv_cnt;
        feed(64'd0, 8);
        vid_beats(s, 64'd0);
        feed(64'hBAD, 1);
        chk("no_beat_after_burst", 64'(vv_cnt - s), 64'd8);

        // Contention with last grant VID: CPU first, then video
        cpu_we = 1'b1;
        cpu_addr = 29'h40;
        cpu_be = 8'h3C;
        cpu_wdata = 64'hCAFE;
        vid_addr = 29'h3000;
        cpu_req = 1'b1;
        vid_req = 1'b1;
        wait_cmd("fair_cmd_seen");
        chk("fair_cpu_first", 64'({ddram_rd, ddram_we}), 64'd1);
        chk("fair_cpu_addr", 64'(ddram_addr), 64'h40);
        tick;
        chk("fair_cpu_ack", 64'(cpu_ack), 64'd1);
        cpu_req = 1'b0;
        vid_cmd(29'h3000, 0);
        s = vv_cnt;
        feed(64'h500, 8);
        vid_beats(s, 64'h500);

        // Contention with last grant VID but urgent video: video first, then CPU read
        vid_urgent = 1'b1;
        vid_addr = 29'h4000;
        cpu_we = 1'b0;
        cpu_addr = 29'h80;
        cpu_req = 1'b1;
        vid_req = 1'b1;
        vid_cmd(29'h4000, 0);
        vid_urgent = 1'b0;
        s = vv_cnt;
        feed(64'h600, 8);
        vid_beats(s, 64'h600);
        tv = '{1'b0, 29'h80, 8'h00, 64'h0, 0, 2, 64'h0808_0808_0808_0808, 64'h0808_0808_0808_0808};
        cpu_xfer(tv);

        // Reset after 3 beats of a burst: outputs clear, remaining beats ignored
        vid_addr = 29'h6000;
        vid_req = 1'b1;
        vid_cmd(29'h6000, 0);
        s = vv_cnt;
        for (int i = 0; i < 3; i++) begin
            ddram_dout = 64'h700 + 64'(i);
            ddram_dout_ready = 1'b1;
            tick;
        end
        reset_n = 1'b0;
        ddram_dout = 64'h703;
        tick;
        chk_reset("reset_mid_burst");
        reset_n = 1'b1;
        feed(64'h704, 4);
        chk("reset_beats_dropped", 64'(vv_cnt - s), 64'd3);
        tv = '{1'b0, 29'h55, 8'h00, 64'h0, 0, 3, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF};
        cpu_xfer(tv);

        chk("rd_we_exclusive", 64'(both_hi), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
